// File: rtl/wbdbgbus_arbiter.sv
// wbdbgbus_arbiter
//   Two-master pipelined Wishbone arbiter. Port A is the UART debug bus
//   master and port B is a second master (CPU/DMA). Whole bus cycles are
//   granted: the owner keeps the slave bus for as long as its CYC stays
//   high and is never preempted.
//
//   Parameters
//     PRIORITY_A   : 1 = A wins ties, 0 = round-robin on ties
//     TIMEOUT_CLKS : stuck-slave watchdog limit in cycles (>= 2)
//     ADDR_W       : address width on all ports
//
//   Ports
//     i_clk, i_rst             clock, synchronous active-high reset
//     i_{a,b}_cyc/stb/we/addr/data   master requests
//     o_{a,b}_ack/err/stall    responses routed to the owner only
//     o_{a,b}_data             slave read data, broadcast to both masters
//     o_wb_*                   slave-side bus driven from the owner
//     i_wb_ack/err/stall/data  slave responses
//     o_grant                  one-hot owner {B,A}, 00 when idle
//
//   Optional feature: define WBDBGBUS_ARB_TIMEOUT_EN to enable the
//   watchdog. With it, an owner that sees no ack/err for TIMEOUT_CLKS-1
//   cycles gets a one-cycle err and the slave-side cycle is dropped until
//   the owner releases CYC.
module wbdbgbus_arbiter #(
  parameter int PRIORITY_A   = 1,
  parameter int TIMEOUT_CLKS = 1024,
  parameter int ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_cyc,
  input  logic              i_a_stb,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [31:0]       i_a_data,
  input  logic              i_b_cyc,
  input  logic              i_b_stb,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [31:0]       i_b_data,
  output logic              o_a_ack,
  output logic              o_a_err,
  output logic              o_a_stall,
  output logic [31:0]       o_a_data,
  output logic              o_b_ack,
  output logic              o_b_err,
  output logic              o_b_stall,
  output logic [31:0]       o_b_data,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic              i_wb_stall,
  input  logic [31:0]       i_wb_data,
  output logic [1:0]        o_grant
);

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DROP} state_t;
  localparam int CW = $clog2(TIMEOUT_CLKS);
  logic [CW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
`endif

  state_t state_q;
  logic   last_q;   // last served master: 0 = A, 1 = B
  logic   own_a, own_b, a_wins, tmo_hit;

  assign own_a = (state_q == OWN_A);
  assign own_b = (state_q == OWN_B);

  // A takes the bus when it is the only requester, when it has fixed
  // priority, or (round-robin) when B was served last.
  assign a_wins = i_a_cyc && (!i_b_cyc || (PRIORITY_A != 0) || last_q);

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
  // A response arriving in the limit cycle still counts, so it rescues the cycle.
  assign tmo_hit = (own_a || own_b) && (cnt_q == CW'(TIMEOUT_CLKS - 1))
                   && !i_wb_ack && !i_wb_err;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE:
          if (a_wins) begin
            state_q <= OWN_A;
            last_q  <= 1'b0;
          end else if (i_b_cyc) begin
            state_q <= OWN_B;
            last_q  <= 1'b1;
          end
        OWN_A:
          if (!i_a_cyc)     state_q <= IDLE;
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
          else if (tmo_hit) state_q <= DROP;
`endif
        OWN_B:
          if (!i_b_cyc)     state_q <= IDLE;
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
          else if (tmo_hit) state_q <= DROP;
        // last_q still names the owner whose cycle was dropped
        DROP:
          if (!(last_q ? i_b_cyc : i_a_cyc)) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
      // Cleared outside an active owned cycle, which covers the grant edge.
      if (!((own_a || own_b) && o_wb_cyc) || i_wb_ack || i_wb_err)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
`endif
    end
  end

  // Slave-side mux: follows the owner's live signals; nothing when idle.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    if (own_a) begin
      o_wb_cyc  = i_a_cyc;
      o_wb_stb  = i_a_stb;
      o_wb_we   = i_a_we;
      o_wb_addr = i_a_addr;
      o_wb_data = i_a_data;
    end else if (own_b) begin
      o_wb_cyc  = i_b_cyc;
      o_wb_stb  = i_b_stb;
      o_wb_we   = i_b_we;
      o_wb_addr = i_b_addr;
      o_wb_data = i_b_data;
    end
  end

  // With no owner, late slave responses fall on the floor.
  assign o_a_ack   = own_a & i_wb_ack;
  assign o_a_err   = own_a & (i_wb_err | tmo_hit);
  assign o_a_stall = own_a ? i_wb_stall : 1'b1;
  assign o_b_ack   = own_b & i_wb_ack;
  assign o_b_err   = own_b & (i_wb_err | tmo_hit);
  assign o_b_stall = own_b ? i_wb_stall : 1'b1;
  assign o_a_data  = i_wb_data;
  assign o_b_data  = i_wb_data;

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
  // A dropped owner still shows in o_grant until it releases CYC.
  assign o_grant = {own_b | ((state_q == DROP) &  last_q),
                    own_a | ((state_q == DROP) & ~last_q)};
`else
  assign o_grant = {own_b, own_a};
`endif

endmodule

// File: tb/tb_wbdbgbus_arbiter.sv
// Directed bench: two arbiters (fixed priority and round-robin) share the
// same stimulus; expected values are worked out by hand per cycle.
module tb_wbdbgbus_arbiter;
  logic        clk = 1'b0, rst;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic        wb_ack, wb_err, wb_stall;
  logic [31:0] wb_rdata;

  // fixed-priority instance outputs
  logic        a_ack, a_err, a_stall, b_ack, b_err, b_stall;
  logic [31:0] a_rd, b_rd, wb_addr, wb_wdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [1:0]  g0;
  // round-robin instance outputs
  logic        r_a_ack, r_a_err, r_a_stall, r_b_ack, r_b_err, r_b_stall;
  logic [31:0] r_a_rd, r_b_rd, r_wb_addr, r_wb_wdata;
  logic        r_wb_cyc, r_wb_stb, r_wb_we;
  logic [1:0]  g1;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wbdbgbus_arbiter #(.PRIORITY_A(1), .TIMEOUT_CLKS(16), .ADDR_W(32)) u_fix (
    .i_clk(clk), .i_rst(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_a_ack(a_ack), .o_a_err(a_err), .o_a_stall(a_stall), .o_a_data(a_rd),
    .o_b_ack(b_ack), .o_b_err(b_err), .o_b_stall(b_stall), .o_b_data(b_rd),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_stall(wb_stall),
    .i_wb_data(wb_rdata), .o_grant(g0));

  wbdbgbus_arbiter #(.PRIORITY_A(0), .TIMEOUT_CLKS(16), .ADDR_W(32)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_a_ack(r_a_ack), .o_a_err(r_a_err), .o_a_stall(r_a_stall), .o_a_data(r_a_rd),
    .o_b_ack(r_b_ack), .o_b_err(r_b_err), .o_b_stall(r_b_stall), .o_b_data(r_b_rd),
    .o_wb_cyc(r_wb_cyc), .o_wb_stb(r_wb_stb), .o_wb_we(r_wb_we), .o_wb_addr(r_wb_addr),
    .o_wb_data(r_wb_wdata), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_stall(wb_stall),
    .i_wb_data(wb_rdata), .o_grant(g1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // inputs are driven 2 time units after the edge, outputs checked 1 later
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {a_cyc, a_stb, a_we, b_cyc, b_stb, b_we} = '0;
    {a_addr, a_data, b_addr, b_data} = '0;
    {wb_ack, wb_err, wb_stall} = '0;
    wb_rdata = '0;
    tick(); tick();
    #1;
    chk("rst_grant", 32'(g0), 32'h0);
    chk("rst_cyc", 32'(wb_cyc), 32'h0);
    chk("rst_stb", 32'(wb_stb), 32'h0);
    chk("rst_ack_err", 32'({a_ack, a_err, b_ack, b_err}), 32'h0);
    chk("rst_stall", 32'({a_stall, b_stall}), 32'h3);
    rst = 1'b0;

    // A single read at 0x10, slave acks two cycles after accepting it
    tick();
    a_cyc = 1; a_stb = 1; a_addr = 32'h10;
    #1 chk("rd_pre_grant", 32'(g0), 32'h0);
    tick();
    #1 chk("rd_grant", 32'(g0), 32'h1);
    chk("rd_wb_cyc", 32'(wb_cyc), 32'h1);
    chk("rd_wb_addr", wb_addr, 32'h10);
    chk("rd_a_stall", 32'(a_stall), 32'h0);
    chk("rd_b_stall", 32'(b_stall), 32'h1);
    a_stb = 0;
    tick(); tick();
    wb_ack = 1; wb_rdata = 32'hDEADBEEF;
    #1 chk("rd_a_ack", 32'(a_ack), 32'h1);
    chk("rd_a_data", a_rd, 32'hDEADBEEF);
    chk("rd_b_ack", 32'(b_ack), 32'h0);
    chk("rd_b_stall2", 32'(b_stall), 32'h1);
    tick();
    wb_ack = 0; a_cyc = 0;
    #1 chk("rd_cyc_follow", 32'(wb_cyc), 32'h0);
    tick();
    #1 chk("rd_idle", 32'(g0), 32'h0);

    // Fixed priority tie x3: A first, B only after A releases
    for (int k = 0; k < 3; k++) begin
      a_cyc = 1; b_cyc = 1;
      tick();
      #1 chk("fix_tie_a", 32'(g0), 32'h1);
      chk("fix_tie_bstall", 32'(b_stall), 32'h1);
      tick();
      a_cyc = 0;
      tick();
      #1 chk("fix_gap", 32'(g0), 32'h0);
      tick();
      #1 chk("fix_then_b", 32'(g0), 32'h2);
      b_cyc = 0;
      tick();
      #1 chk("fix_end_idle", 32'(g0), 32'h0);
    end

    // Round-robin: fresh reset leaves last_served = B, so A, B, A, B
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_cyc = 1; b_cyc = 1;
      tick();
      #1 chk("rr_order", 32'(g1), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_fix_a", 32'(g0), 32'h1);
      tick();
      a_cyc = 0; b_cyc = 0;
      tick();
      #1 chk("rr_one_idle", 32'(g1), 32'h0);
    end

    // B burst of 4 pipelined writes; A requests mid-burst and must wait
    b_cyc = 1; b_stb = 1; b_we = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      b_addr = 32'h100 + 32'(4 * i); b_data = 32'(i);
      wb_ack = (i > 0);
      if (i == 1) begin a_cyc = 1; a_stb = 1; a_addr = 32'h20; end
      #1 chk("bw_grant", 32'(g0), 32'h2);
      chk("bw_addr", wb_addr, 32'h100 + 32'(4 * i));
      chk("bw_data", wb_wdata, 32'(i));
      chk("bw_we", 32'(wb_we), 32'h1);
      chk("bw_b_ack", 32'(b_ack), 32'(i > 0));
      chk("bw_a_ack", 32'(a_ack), 32'h0);
      chk("bw_a_stall", 32'(a_stall), 32'h1);
      tick();
    end
    b_stb = 0; wb_ack = 1;
    #1 chk("bw_last_ack", 32'(b_ack), 32'h1);
    chk("bw_a_ack_end", 32'(a_ack), 32'h0);
    tick();
    wb_ack = 0; b_cyc = 0; b_we = 0;
    #1 chk("bw_still_b", 32'(g0), 32'h2);
    tick();
    #1 chk("bw_gap", 32'(g0), 32'h0);
    tick();
    #1 chk("bw_a_granted", 32'(g0), 32'h1);
    chk("bw_a_addr", wb_addr, 32'h20);

    // Reset while A owns with an ack pending; a late ack goes nowhere
    rst = 1'b1;
    tick();
    rst = 1'b0; a_cyc = 0; a_stb = 0;
    wb_ack = 1;
    #1 chk("rst_mid_cyc", 32'(wb_cyc), 32'h0);
    chk("rst_mid_grant", 32'(g0), 32'h0);
    chk("rst_late_ack", 32'({a_ack, b_ack, r_a_ack, r_b_ack}), 32'h0);
    tick();
    wb_ack = 0;

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
    // Stuck slave: err 15 cycles after grant, then cycle dropped
    a_cyc = 1; a_stb = 1; wb_stall = 1;
    tick();
    for (int n = 0; n < 16; n++) begin
      #1 chk("tmo_err", 32'(a_err), 32'(n == 15));
      chk("tmo_cyc_held", 32'(wb_cyc), 32'h1);
      tick();
    end
    #1 chk("tmo_drop_cyc", 32'(wb_cyc), 32'h0);
    chk("tmo_drop_stb", 32'(wb_stb), 32'h0);
    chk("tmo_drop_stall", 32'(a_stall), 32'h1);
    chk("tmo_err_once", 32'(a_err), 32'h0);
    tick();
    #1 chk("tmo_drop_hold", 32'(wb_cyc), 32'h0);
    a_cyc = 0; a_stb = 0; wb_stall = 0;
    tick();
    #1 chk("tmo_idle", 32'(g0), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
